// File: rtl/rs232_cmd_responder.sv
// rs232_cmd_responder
// Device-side end of the 3-byte RS232 command protocol (cmd, address, data).
// Assembles frames from the UART receiver, issues one register-bus write or
// read per frame, and returns read data as a single byte through the UART
// transmitter. An inter-byte timeout discards partial frames.
//
// Build option: RS232_WRITE_ECHO_EN - when defined, write frames echo the
// written byte through the transmitter as an acknowledgement.
//
// Ports:
//   CLK_50MHZ  in   system clock, rising edge
//   RST        in   synchronous reset, active-high
//   RX_DATA    in   [7:0] received byte, qualified by RX_VALID
//   RX_VALID   in   one-cycle pulse per received byte
//   TX_DATA    out  [7:0] byte to transmit
//   TX_TRG     out  one-cycle transmit start pulse
//   TX_BUSY    in   transmitter busy, no TX_TRG is issued while high
//   REG_ADDR   out  [7:0] register address
//   REG_WDATA  out  [7:0] register write data
//   REG_WE     out  one-cycle write strobe
//   REG_RE     out  one-cycle read strobe
//   REG_RDATA  in   [7:0] read data, valid the cycle after REG_RE
//   FRAME_ERR  out  one-cycle pulse on timeout or dropped byte
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for the cmd byte
// WAIT_ADDR | cmd latched, waiting for the address byte (timeout armed)
// WAIT_DATA | address latched, waiting for the data byte (timeout armed)
// EXEC      | strobe cycle (REG_WE or REG_RE high)
// READ_CAP  | read data on the bus, captured into TX_DATA
// SEND      | waiting for the transmitter to be free, then TX_TRG

module rs232_cmd_responder #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int TO_W           = 16
) (
   input  logic       CLK_50MHZ,
   input  logic       RST,
   input  logic [7:0] RX_DATA,
   input  logic       RX_VALID,
   output logic [7:0] TX_DATA,
   output logic       TX_TRG,
   input  logic       TX_BUSY,
   output logic [7:0] REG_ADDR,
   output logic [7:0] REG_WDATA,
   output logic       REG_WE,
   output logic       REG_RE,
   input  logic [7:0] REG_RDATA,
   output logic       FRAME_ERR
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ADDR,
      WAIT_DATA,
      EXEC,
      READ_CAP,
      SEND
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state;
   logic            is_read;
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge CLK_50MHZ) begin
      if (RST) begin
         state     <= IDLE;
         is_read   <= 1'b0;
         to_cnt    <= '0;
         TX_DATA   <= 8'h00;
         TX_TRG    <= 1'b0;
         REG_ADDR  <= 8'h00;
         REG_WDATA <= 8'h00;
         REG_WE    <= 1'b0;
         REG_RE    <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         // pulses and the timeout counter fall back to zero unless a
         // branch below says otherwise
         REG_WE    <= 1'b0;
         REG_RE    <= 1'b0;
         TX_TRG    <= 1'b0;
         FRAME_ERR <= 1'b0;
         to_cnt    <= '0;

         case (state)
            IDLE: begin
               if (RX_VALID) begin
                  is_read <= RX_DATA[0];
                  state   <= WAIT_ADDR;
               end
            end

            // a byte arriving on the timeout cycle is accepted
            WAIT_ADDR: begin
               if (RX_VALID) begin
                  REG_ADDR <= RX_DATA;
                  state    <= WAIT_DATA;
               end else if (to_cnt == TO_LAST) begin
                  FRAME_ERR <= 1'b1;
                  state     <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            // strobes are registered here so they are high during EXEC
            WAIT_DATA: begin
               if (RX_VALID) begin
                  REG_WDATA <= RX_DATA;
                  REG_WE    <= ~is_read;
                  REG_RE    <= is_read;
                  state     <= EXEC;
               end else if (to_cnt == TO_LAST) begin
                  FRAME_ERR <= 1'b1;
                  state     <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            EXEC: begin
               FRAME_ERR <= RX_VALID;
               if (is_read) begin
                  state <= READ_CAP;
               end else begin
`ifdef RS232_WRITE_ECHO_EN
                  TX_DATA <= REG_WDATA;
                  TX_TRG  <= ~TX_BUSY;
                  state   <= SEND;
`else
                  state   <= IDLE;
`endif
               end
            end

            // TX_TRG is decided on the same edge as the capture so the
            // trigger lands two clocks after REG_RE when the UART is free
            READ_CAP: begin
               FRAME_ERR <= RX_VALID;
               TX_DATA   <= REG_RDATA;
               TX_TRG    <= ~TX_BUSY;
               state     <= SEND;
            end

            // TX_TRG high means the trigger is being issued this cycle
            SEND: begin
               FRAME_ERR <= RX_VALID;
               if (TX_TRG) begin
                  state <= IDLE;
               end else if (!TX_BUSY) begin
                  TX_TRG <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_cmd_responder.sv
module tb_rs232_cmd_responder;

   localparam int TC = 40;
`ifdef RS232_WRITE_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   logic       CLK_50MHZ = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] RX_DATA = 8'h00;
   logic       RX_VALID = 1'b0;
   logic [7:0] TX_DATA;
   logic       TX_TRG;
   logic       TX_BUSY = 1'b0;
   logic [7:0] REG_ADDR;
   logic [7:0] REG_WDATA;
   logic       REG_WE;
   logic       REG_RE;
   logic [7:0] REG_RDATA = 8'h00;
   logic       FRAME_ERR;

   rs232_cmd_responder #(.TIMEOUT_CYCLES(TC), .TO_W(8)) dut (
      .CLK_50MHZ (CLK_50MHZ),
      .RST       (RST),
      .RX_DATA   (RX_DATA),
      .RX_VALID  (RX_VALID),
      .TX_DATA   (TX_DATA),
      .TX_TRG    (TX_TRG),
      .TX_BUSY   (TX_BUSY),
      .REG_ADDR  (REG_ADDR),
      .REG_WDATA (REG_WDATA),
      .REG_WE    (REG_WE),
      .REG_RE    (REG_RE),
      .REG_RDATA (REG_RDATA),
      .FRAME_ERR (FRAME_ERR)
   );

   always #5 CLK_50MHZ = ~CLK_50MHZ;

   int n_checks = 0;
   int n_errs   = 0;

   // register contents as the bus slave holds them, and as the model expects
   logic [7:0] bus_regs   [256];
   logic [7:0] model_regs [256];

   // event log, sampled 1 ns after each rising edge; cyc = edges so far
   int cyc = 0;
   int we_n = 0, re_n = 0, trg_n = 0, err_n = 0, both_n = 0, busy_viol = 0;
   int we_cyc, re_cyc, trg_cyc, err_cyc;
   logic [7:0] we_addr, we_data, re_addr, trg_data;
   logic       re_prev = 1'b0;
   logic [7:0] raddr_prev = 8'h00;

   always begin
      @(posedge CLK_50MHZ);
      #1;
      cyc++;
      // read data is presented only during the cycle after REG_RE
      REG_RDATA  = re_prev ? bus_regs[raddr_prev] : 8'($urandom);
      re_prev    = REG_RE;
      raddr_prev = REG_ADDR;
      if (REG_WE) begin
         we_n++; we_cyc = cyc; we_addr = REG_ADDR; we_data = REG_WDATA;
         bus_regs[REG_ADDR] = REG_WDATA;
      end
      if (REG_RE) begin
         re_n++; re_cyc = cyc; re_addr = REG_ADDR;
      end
      if (REG_WE && REG_RE) both_n++;
      if (TX_TRG) begin
         trg_n++; trg_cyc = cyc; trg_data = TX_DATA;
         if (TX_BUSY) busy_viol++;
      end
      if (FRAME_ERR) begin
         err_n++; err_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // all tasks start and end on a falling edge
   task automatic send_byte(input logic [7:0] b, output int e);
      RX_DATA  = b;
      RX_VALID = 1'b1;
      e = cyc + 1;
      @(negedge CLK_50MHZ);
      RX_VALID = 1'b0;
      RX_DATA  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK_50MHZ);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk(tag, 32'({TX_DATA, TX_TRG, REG_ADDR, REG_WDATA, REG_WE, REG_RE, FRAME_ERR}), 32'd0);
   endtask

   // Full frame. busy_len: cycles TX_BUSY stays high after the data byte.
   // extra_at: index within the busy window at which a stray byte is sent.
   task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input int gap1, input int gap2,
                            input int busy_len, input int extra_at);
      int s_we, s_re, s_trg, s_err;
      int e, d, x, first_free, exp_trg;
      bit is_rd;
      s_we = we_n; s_re = re_n; s_trg = trg_n; s_err = err_n;
      is_rd = cmd[0];
      x = -1;
      send_byte(cmd, e);
      idle(gap1);
      send_byte(addr, e);
      idle(gap2);
      TX_BUSY = (busy_len > 0);
      send_byte(data, d);
      for (int i = 0; i < busy_len; i++) begin
         if (is_rd && i >= 2 && i % 25 == 2) chk("tx_hold", TX_DATA, model_regs[addr]);
         if (i == extra_at) begin
            RX_DATA  = 8'($urandom);
            RX_VALID = 1'b1;
            x = cyc + 1;
         end
         @(negedge CLK_50MHZ);
         RX_VALID = 1'b0;
      end
      TX_BUSY = 1'b0;
      idle(8);

      first_free = (busy_len > 0) ? d + busy_len + 1 : d;
      chk("we_count", we_n - s_we, is_rd ? 0 : 1);
      chk("re_count", re_n - s_re, is_rd ? 1 : 0);
      if (is_rd) begin
         chk("re_cycle", re_cyc, d);
         chk("re_addr", re_addr, addr);
      end else begin
         chk("we_cycle", we_cyc, d);
         chk("we_addr", we_addr, addr);
         chk("we_data", we_data, data);
      end
      chk("trg_count", trg_n - s_trg, (is_rd || ECHO) ? 1 : 0);
      if (is_rd || ECHO) begin
         exp_trg = is_rd ? d + 2 : d + 1;
         if (first_free > exp_trg) exp_trg = first_free;
         chk("trg_cycle", trg_cyc, exp_trg);
         chk("trg_data", trg_data, is_rd ? model_regs[addr] : data);
      end
      chk("err_count", err_n - s_err, (x >= 0) ? 1 : 0);
      if (x >= 0) chk("err_cycle", err_cyc, x);
      if (!is_rd) model_regs[addr] = data;
   endtask

   // Partial frame (cmd only, or cmd + addr) followed by silence.
   task automatic run_timeout(input bit with_addr, input logic [7:0] addr);
      int s_we, s_re, s_err, e;
      s_we = we_n; s_re = re_n; s_err = err_n;
      send_byte({7'($urandom), 1'b0}, e);
      if (with_addr) send_byte(addr, e);
      idle(TC + 6);
      chk("to_err_count", err_n - s_err, 1);
      chk("to_err_cycle", err_cyc, e + TC);
      chk("to_no_we", we_n - s_we, 0);
      chk("to_no_re", re_n - s_re, 0);
   endtask

   initial begin
      int e;
      logic [7:0] cmd, addr, data;
      int g1, g2, bl, ex;

      for (int i = 0; i < 256; i++) begin
         bus_regs[i]   = 8'($urandom);
         model_regs[i] = bus_regs[i];
      end
      bus_regs[8'h19]   = 8'hA5;
      model_regs[8'h19] = 8'hA5;

      RST = 1'b1;
      repeat (3) @(negedge CLK_50MHZ);
      chk_reset_outs("reset_outputs");
      RST = 1'b0;
      idle(2);

      run_frame(8'h00, 8'h18, 8'h03, 0, 0, 0, -1);
      run_frame(8'h01, 8'h19, 8'hFF, 0, 0, 0, -1);
      // transmitter backpressure for 100 clocks
      run_frame(8'h01, 8'h19, 8'h7E, 1, 1, 100, -1);
      // timeout after addr, then the same frame completed
      run_timeout(1'b1, 8'h1A);
      run_frame(8'h00, 8'h1A, 8'h30, 0, 0, 0, -1);
      run_timeout(1'b0, 8'h00);
      // longest gaps that still do not time out
      run_frame(8'h00, 8'h21, 8'h5C, TC - 1, TC - 1, 0, -1);
      run_frame(8'hFF, 8'h21, 8'h00, 0, 0, 0, -1);
      // stray byte during SEND, and during EXEC
      run_frame(8'h01, 8'h18, 8'hFF, 0, 0, 30, 10);
      run_frame(8'h00, 8'h40, 8'h99, 2, 0, 0, -1);
      run_frame(8'h01, 8'h40, 8'h00, 0, 0, 4, 0);

      // reset mid-frame
      send_byte(8'h00, e);
      send_byte(8'h55, e);
      RST = 1'b1;
      @(negedge CLK_50MHZ);
      RST = 1'b0;
      chk_reset_outs("midframe_reset_outputs");
      idle(1);
      run_frame(8'h00, 8'h22, 8'h6D, 0, 0, 0, -1);
      run_frame(8'h01, 8'h22, 8'h00, 0, 0, 0, -1);

      for (int f = 0; f < 20; f++) begin
         cmd  = 8'($urandom);
         addr = 8'($urandom_range(0, 15));
         data = 8'($urandom);
         g1 = (f % 5 == 4) ? TC - 1 : int'($urandom_range(0, 5));
         g2 = (f % 7 == 3) ? TC - 1 : int'($urandom_range(0, 5));
         bl = int'($urandom_range(0, 6));
         ex = (cmd[0] && bl > 0 && f % 3 == 0) ? int'($urandom_range(0, bl - 1)) : -1;
         run_frame(cmd, addr, data, g1, g2, bl, ex);
      end

      chk("strobe_overlap", both_n, 0);
      chk("trg_while_busy", busy_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
